pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each data word (register operands, immediate, etc. packed by caller).
REQ-002 SHALL have parameter CTRL_W, default 8: width of the control bundle (ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, ALUOp, ...).
REQ-003 SHALL have port clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid_i  in  1  upstream stage holds a valid instruction.
REQ-006 SHALL have port in_ready_o  out  1  stage can accept this cycle.
REQ-007 SHALL have port in_data_i  in  DATA_W  upstream data payload.
REQ-008 SHALL have port in_ctrl_i  in  CTRL_W  upstream control bundle.
REQ-009 SHALL have port flush_i  in  1  synchronous squash of all held entries.
REQ-010 SHALL have port out_valid_o  out  1  downstream payload valid.
REQ-011 SHALL have port out_ready_i  in  1  downstream consumes this cycle.
REQ-012 SHALL have port out_data_o  out  DATA_W  registered data payload.
REQ-013 SHALL have port out_ctrl_o  out  CTRL_W  registered control; all-zero whenever out_valid_o=0 (bubble).
REQ-014 SHALL have port occupancy_o  out  2  number of held entries, 0..2.

Function
REQ-015 Accept = in_valid_i & in_ready_o; consume = out_valid_o & out_ready_i; no other transfers.
REQ-016 States: EMPTY (0 entries), FULL (main reg), SKID (main + skid reg); occupancy_o = 0/1/2 respectively.
REQ-017 EMPTY: accept -> FULL, payload visible on out_* next cycle (latency 1); else stay.
REQ-018 FULL: accept&consume -> FULL, main reloaded with input; accept only -> SKID, input captured in skid reg; consume only -> EMPTY; neither -> hold.
REQ-019 SKID: consume -> FULL, main loaded from skid reg; else hold; accept impossible.
REQ-020 in_ready_o SHALL be registered: 1 in EMPTY/FULL, 0 in SKID; no combinational path from out_ready_i.
REQ-021 While out_valid_o=1 and out_ready_i=0, out_data_o and out_ctrl_o SHALL be held bit-stable.
REQ-022 Ordering SHALL be strict FIFO; no entry dropped or duplicated.
REQ-023 flush_i=1 has top priority: next state EMPTY, out_valid_o=0, out_ctrl_o=0, in_ready_o=1; input presented that cycle is discarded; out_data_o may hold stale value.
REQ-024 flush_i and consume in same cycle: consume counts downstream, state still EMPTY.
REQ-025 Every control bit, including ALUSrc, SHALL propagate from in_ctrl_i, never from its own output.

Reset
REQ-026 rst_i=0 SHALL immediately force state EMPTY, out_valid_o=0, out_data_o=0, out_ctrl_o=0, occupancy_o=0, in_ready_o=1, skid reg cleared.
REQ-027 Reset asserted mid-transfer SHALL discard all entries; first accept after rst_i rises behaves as from EMPTY.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_BUF_EN defined: skid reg and SKID state present, behaviour per REQ-016..REQ-020.
REQ-029 Macro undefined: no skid reg; states EMPTY/FULL only; in_ready_o = !out_valid_o | out_ready_i (combinational); occupancy_o max 1; all other requirements unchanged.

Verification
REQ-030 Reset then in_valid_i=1, in_data_i=0x0000_00AA, in_ctrl_i=0x15, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=0xAA, out_ctrl_o=0x15.
REQ-031 out_ready_i=0, push 0x11 then 0x22 (skid on) -> occupancy_o=2, in_ready_o=0, out_data_o=0x11 stable; raise out_ready_i -> 0x11 then 0x22 over two cycles.
REQ-032 Occupancy 2, flush_i=1 with in_valid_i=1 data 0x33 -> next cycle out_valid_o=0, out_ctrl_o=0, occupancy_o=0, in_ready_o=1; 0x33 never emitted.
REQ-033 Random in_valid_i/out_ready_i 10k cycles, incrementing data -> output sequence strictly incrementing, no gaps, out_* stable while stalled.
REQ-034 Assert rst_i=0 mid-cycle at occupancy 1 -> outputs zero without clock edge; in_ready_o=1.
REQ-035 Macro undefined, out_valid_o=1, out_ready_i toggled -> in_ready_o follows out_ready_i same cycle, occupancy_o never exceeds 1.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one pipeline register stage (data + control bundle)
// with valid/ready handshake, synchronous flush and an optional skid
// register.
//
// Build option: define PIPE_STAGE_SKID_BUF_EN to add the skid register.
// With it, in_ready_o is a flop and there is no combinational path from
// out_ready_i. Without it, the stage holds at most one entry and
// in_ready_o = !out_valid_o | out_ready_i.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | nothing held, out_valid_o=0, out_ctrl_o=0
// ST_FULL  | main register holds the entry shown on out_*
// ST_SKID  | main + skid register both hold entries; upstream stalled
//            (exists only when PIPE_STAGE_SKID_BUF_EN is defined)

module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o
);

`ifdef PIPE_STAGE_SKID_BUF_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1
  } state_t;
`endif

  state_t            state_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic              accept;
  logic              consume;

`ifdef PIPE_STAGE_SKID_BUF_EN
  logic              in_ready_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  assign in_ready_o = in_ready_q;
`else
  assign in_ready_o = !out_valid_q | out_ready_i;
`endif

  assign accept      = in_valid_i & in_ready_o;
  assign consume     = out_valid_q & out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_data_q;
  // main_ctrl_q is cleared whenever the stage drops to empty, so a bubble
  // always shows an all-zero control bundle.
  assign out_ctrl_o  = main_ctrl_q;
  // State encoding equals the number of held entries.
  assign occupancy_o = 2'(state_q);

`ifdef PIPE_STAGE_SKID_BUF_EN
  // Stage FSM with skid register: flush wins, else advance on accept/consume.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush_i) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_data_q <= in_data_i;
            main_ctrl_q <= in_ctrl_i;
            out_valid_q <= 1'b1;
            state_q     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && consume) begin
            main_data_q <= in_data_i;
            main_ctrl_q <= in_ctrl_i;
          end else if (accept) begin
            skid_data_q <= in_data_i;
            skid_ctrl_q <= in_ctrl_i;
            in_ready_q  <= 1'b0;
            state_q     <= ST_SKID;
          end else if (consume) begin
            main_ctrl_q <= '0;
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          // in_ready_o is low here, so only a consume can move the FSM.
          if (consume) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_FULL;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          main_ctrl_q <= '0;
        end
      endcase
    end
  end
`else
  // Single-entry stage FSM: flush wins, else advance on accept/consume.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else if (flush_i) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_data_q <= in_data_i;
            main_ctrl_q <= in_ctrl_i;
            out_valid_q <= 1'b1;
            state_q     <= ST_FULL;
          end
        end
        ST_FULL: begin
          // in_ready_o already implies consume when full, so accept
          // without consume cannot occur.
          if (accept) begin
            main_data_q <= in_data_i;
            main_ctrl_q <= in_ctrl_i;
          end else if (consume) begin
            main_ctrl_q <= '0;
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          main_ctrl_q <= '0;
        end
      endcase
    end
  end
`endif

endmodule
